spi_master_tx: RTL and testbench
================================

SPI_MASTER_TX -- requirements
Module: spi_master_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range >=2.
REQ-002 Parameter CS_GAP, default 8: cs_n-high clk cycles between the two words of one transaction; legal range >=1.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle transaction request; accepted only when busy=0.
REQ-006 xdata_tx  input  16  word 0 (X word, bit15=1 tag), sampled at start acceptance.
REQ-007 ydata_tx  input  16  word 1 (Y word, bit15=0 tag), sampled at start acceptance.
REQ-008 miso  input  1  serial data from slave.
REQ-009 busy  output  1  high from the cycle after acceptance through the last cs_n-low cycle.
REQ-010 done  output  1  one-cycle pulse at transaction end.
REQ-011 sclk  output  1  SPI clock, CPOL=0.
REQ-012 mosi  output  1  serial data, MSB first.
REQ-013 cs_n  output  1  active-low chip select, one frame per word.
REQ-014 rx_data  output  32  {word0 received, word1 received}.

Function
REQ-015 SPI mode 0: mosi changes while sclk low; slave and master sample on sclk rising edge.
REQ-016 FSM states IDLE, SETUP, SHIFT, HOLD, GAP, DONE; IDLE->SETUP on accepted start; SETUP->SHIFT after CLK_DIV cycles; SHIFT->HOLD after 16 bits; HOLD->GAP (after word 0) or DONE (after word 1) after CLK_DIV cycles; GAP->SETUP after CS_GAP cycles; DONE->IDLE after 1 cycle.
REQ-017 On acceptance (cycle T0), both words latch into internal shift registers; input changes after T0 do not affect the transaction.
REQ-018 SETUP: cs_n=0, sclk=0, mosi=bit15 of current word, CLK_DIV cycles.
REQ-019 SHIFT: per bit, CLK_DIV cycles sclk=0 then CLK_DIV cycles sclk=1; mosi advances to the next bit in the cycle sclk falls; 32*CLK_DIV cycles per word.
REQ-020 HOLD: cs_n=0, sclk=0 for CLK_DIV cycles; cs_n frame per word = 34*CLK_DIV cycles.
REQ-021 GAP and IDLE: cs_n=1, sclk=0, mosi=0.
REQ-022 Defaults (CLK_DIV=4, CS_GAP=8): cs_n low T0+1..T0+136, high T0+137..T0+144, low T0+145..T0+280; done=1, busy=0, cs_n=1 at T0+281.
REQ-023 start while busy=1 is ignored with no queuing; start in the done cycle is accepted (FSM in DONE counts as not busy).
REQ-024 busy=0 in IDLE and DONE; done=1 only in DONE.
REQ-025 All outputs registered; sclk, mosi, cs_n glitch-free.

Reset
REQ-026 reset=1 at any clk edge, including mid-frame, forces IDLE next cycle: cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, counters cleared; an aborted transaction produces no done pulse.
REQ-027 start asserted together with reset is ignored.

Configuration
REQ-028 Macro SPI_RX_CAPTURE_EN defined: miso sampled in the clk cycle sclk rises, shifted MSB first into a per-word receive register; rx_data[31:16]=word 0, rx_data[15:0]=word 1, both updated in the DONE cycle and held until the next DONE or reset.
REQ-029 SPI_RX_CAPTURE_EN undefined: no receive logic; rx_data constant 0; miso unused.

Verification
REQ-030 Defaults, start with xdata_tx=16'h8155, ydata_tx=16'h00AA -> mosi frames 1000_0001_0101_0101 then 0000_0000_1010_1010; 16 sclk rising edges per frame; done at T0+281.
REQ-031 start held high through whole transaction -> exactly one transaction, then a second accepted in the done cycle; cs_n low again the cycle after done.
REQ-032 reset pulsed at T0+50 -> cs_n=1, sclk=0, busy=0 at T0+51; no done pulse; next start runs a full, correct transaction.
REQ-033 SPI_RX_CAPTURE_EN defined, slave model returns 16'h1234 then 16'hABCD on miso -> rx_data=32'h1234ABCD in done cycle; undefined -> rx_data=0.
REQ-034 CLK_DIV=2, CS_GAP=1 -> frame 68 cycles, gap 1 cycle, done at T0+138; xdata_tx changed at T0+5 has no effect on mosi.

Source files
------------

// File: rtl/spi_master_tx_if.sv
// rtl/spi_master_tx_if.sv - host and SPI-side signal bundle for spi_master_tx
//
// Purpose: groups the transaction handshake (start/busy/done), the two
// transmit words, the receive result and the four SPI wires.
// Ports (signals):
//   start     1   one-cycle transaction request (host -> master)
//   xdata_tx  16  word 0, sampled at acceptance
//   ydata_tx  16  word 1, sampled at acceptance
//   miso      1   serial data from the SPI slave
//   busy      1   transaction in progress
//   done      1   one-cycle end-of-transaction pulse
//   sclk      1   SPI clock, idles low
//   mosi      1   serial data to the slave, MSB first
//   cs_n      1   active-low chip select, one frame per word
//   rx_data   32  {word 0 received, word 1 received}
// Modports: master (the SPI master block), slave (host/bench side).

interface spi_master_tx_if;
  logic        start;
  logic [15:0] xdata_tx;
  logic [15:0] ydata_tx;
  logic        miso;
  logic        busy;
  logic        done;
  logic        sclk;
  logic        mosi;
  logic        cs_n;
  logic [31:0] rx_data;

  modport master (
    input  start, xdata_tx, ydata_tx, miso,
    output busy, done, sclk, mosi, cs_n, rx_data
  );

  modport slave (
    output start, xdata_tx, ydata_tx, miso,
    input  busy, done, sclk, mosi, cs_n, rx_data
  );
endinterface

// File: rtl/spi_master_tx.sv
// rtl/spi_master_tx.sv - two-word SPI mode 0 transmit master (X then Y word)
//
// Purpose: on an accepted start, sends xdata_tx then ydata_tx as two separate
// 16-bit cs_n frames, MSB first, with CS_GAP idle cycles between the frames.
// Parameters:
//   CLK_DIV  sclk half-period in clk cycles (>= 2)
//   CS_GAP   cs_n-high cycles between the two frames (>= 1)
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    spi_master_tx_if.master (start, xdata_tx, ydata_tx, miso,
//          busy, done, sclk, mosi, cs_n, rx_data)
// Optional feature: define SPI_RX_CAPTURE_EN to capture miso into rx_data;
// without it rx_data is constant zero and miso is ignored.

module spi_master_tx #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic            clk,
  input  logic            reset,
  spi_master_tx_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, DONE} state_t;

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_M1 = 16'(CS_GAP - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [3:0]  r_bit;
  logic        r_word;     // 0 while sending word 0, 1 while sending word 1
  logic [15:0] r_shift;    // current transmit word, MSB is the bit on mosi
  logic [15:0] r_ydata;
  logic        r_sclk;
  logic        r_mosi;
  logic        r_cs_n;
  logic        r_busy;
  logic        r_done;

  logic w_accept;
  logic w_div_end;

  // DONE counts as not busy, so a start in the done cycle is taken.
  assign w_accept  = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_div_end = (r_cnt == DIV_M1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_word  <= 1'b0;
      r_shift <= '0;
      r_ydata <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_state <= SETUP;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_word  <= 1'b0;
            r_shift <= bus.xdata_tx;
            r_ydata <= bus.ydata_tx;
            r_cs_n  <= 1'b0;
            r_mosi  <= bus.xdata_tx[15];
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        SETUP: begin
          if (w_div_end) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        SHIFT: begin
          if (w_div_end) begin
            r_cnt <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              // Falling edge: present the next bit, or end the frame.
              r_sclk <= 1'b0;
              if (r_bit == 4'd15) begin
                r_state <= HOLD;
              end else begin
                r_bit   <= r_bit + 4'd1;
                r_shift <= {r_shift[14:0], 1'b0};
                r_mosi  <= r_shift[14];
              end
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        HOLD: begin
          if (w_div_end) begin
            r_cnt  <= '0;
            r_bit  <= '0;
            r_cs_n <= 1'b1;
            r_mosi <= 1'b0;
            if (!r_word) begin
              r_state <= GAP;
              r_word  <= 1'b1;
              r_shift <= r_ydata;
            end else begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        GAP: begin
          if (r_cnt == GAP_M1) begin
            r_state <= SETUP;
            r_cnt   <= '0;
            r_cs_n  <= 1'b0;
            r_mosi  <= r_shift[15];
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sclk = r_sclk;
  assign bus.mosi = r_mosi;
  assign bus.cs_n = r_cs_n;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

`ifdef SPI_RX_CAPTURE_EN
  logic [15:0] r_rx_shift;
  logic [15:0] r_rx_w0;
  logic [31:0] r_rx_data;
  logic        w_sample;

  // First clk cycle of each sclk-high phase; miso is stable here in mode 0.
  assign w_sample = (r_state == SHIFT) && r_sclk && (r_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_shift <= '0;
      r_rx_w0    <= '0;
      r_rx_data  <= '0;
    end else begin
      if (w_sample) begin
        r_rx_shift <= {r_rx_shift[14:0], bus.miso};
      end
      if ((r_state == HOLD) && w_div_end) begin
        if (!r_word) begin
          r_rx_w0 <= r_rx_shift;
        end else begin
          r_rx_data <= {r_rx_w0, r_rx_shift};
        end
      end
    end
  end

  assign bus.rx_data = r_rx_data;
`else
  logic w_miso_unused;
  assign w_miso_unused = bus.miso;
  assign bus.rx_data   = 32'd0;
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// tb/tb_spi_master_tx.sv - scoreboard bench for spi_master_tx

module tb_spi_master_tx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_master_tx_if bus1();
  spi_master_tx_if bus2();

  spi_master_tx #(.CLK_DIV(4), .CS_GAP(8)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  spi_master_tx #(.CLK_DIV(2), .CS_GAP(1)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  localparam logic [15:0] SL0 = 16'h1234;
  localparam logic [15:0] SL1 = 16'hABCD;
`ifdef SPI_RX_CAPTURE_EN
  localparam logic [31:0] EXP_RX = {SL0, SL1};
`else
  localparam logic [31:0] EXP_RX = 32'd0;
`endif
  localparam int LAT1 = 281;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int n_done  = 0;
  bit abort_flag = 1'b0;

  logic [15:0] q_frame[$];
  logic [31:0] q_rx[$];
  int          q_t0[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave model and frame/done monitor for dut1, all sampled on negedge.
  initial begin
    logic        p_sclk = 1'b0;
    logic        p_cs   = 1'b1;
    logic        p_busy = 1'b0;
    logic [15:0] s_word = 16'd0;
    int          s_idx  = 0;
    logic [15:0] fr     = 16'd0;
    int          nb     = 0;
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (p_cs && !bus1.cs_n) begin
        s_word    = p_busy ? SL1 : SL0;
        s_idx     = 0;
        bus1.miso = s_word[15];
        fr        = 16'd0;
        nb        = 0;
      end else if (!bus1.cs_n && p_sclk && !bus1.sclk) begin
        s_idx++;
        if (s_idx < 16) bus1.miso = s_word[15-s_idx];
      end
      if (!p_sclk && bus1.sclk) begin
        fr = {fr[14:0], bus1.mosi};
        nb++;
      end
      if (!p_cs && bus1.cs_n && !abort_flag) begin
        if (q_frame.size() == 0) begin
          check_eq("frame_unexpected", 32'd1, 32'd0);
        end else begin
          e = q_frame.pop_front();
          check_eq("frame_mosi", {16'd0, fr}, {16'd0, e});
          check_eq("frame_sclk_rises", 32'(nb), 32'd16);
        end
      end
      if (bus1.done) begin
        n_done++;
        if (q_rx.size() == 0 || q_t0.size() == 0) begin
          check_eq("done_unexpected", 32'd1, 32'd0);
        end else begin
          check_eq("done_rx_data", bus1.rx_data, q_rx.pop_front());
          check_eq("done_latency", 32'(cyc - q_t0.pop_front()), 32'(LAT1));
          check_eq("done_busy", {31'd0, bus1.busy}, 32'd0);
        end
      end
      p_sclk = bus1.sclk;
      p_cs   = bus1.cs_n;
      p_busy = bus1.busy;
    end
  end

  // Called at a negedge; returns at the negedge of cycle T0+1.
  task automatic start_txn(input logic [15:0] x, input logic [15:0] y);
    bus1.xdata_tx = x;
    bus1.ydata_tx = y;
    bus1.start    = 1'b1;
    q_frame.push_back(x);
    q_frame.push_back(y);
    q_rx.push_back(EXP_RX);
    q_t0.push_back(cyc);
    @(negedge clk);
    bus1.start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 700 && n_done < target; i++) @(negedge clk);
    check_eq("done_wait", {31'd0, (n_done >= target)}, 32'd1);
  endtask

  initial begin
    int          offs [7] = '{1, 136, 137, 144, 145, 280, 281};
    logic        exp_cs [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int          t0;
    int          dn;
    logic [15:0] fr2;
    logic [15:0] q2[$];
    logic        p_sclk2;
    logic        p_cs2;

    reset = 1'b1;
    bus1.start = 1'b1; bus1.xdata_tx = 16'hFFFF; bus1.ydata_tx = 16'hFFFF; bus1.miso = 1'b0;
    bus2.start = 1'b0; bus2.xdata_tx = 16'd0;    bus2.ydata_tx = 16'd0;    bus2.miso = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus1.start = 1'b0;
    @(negedge clk);
    check_eq("rst_cs_n",    {31'd0, bus1.cs_n}, 32'd1);
    check_eq("rst_sclk",    {31'd0, bus1.sclk}, 32'd0);
    check_eq("rst_mosi",    {31'd0, bus1.mosi}, 32'd0);
    check_eq("rst_busy",    {31'd0, bus1.busy}, 32'd0);
    check_eq("rst_done",    {31'd0, bus1.done}, 32'd0);
    check_eq("rst_rx_data", bus1.rx_data, 32'd0);

    // Reference transaction with cs_n timeline.
    start_txn(16'h8155, 16'h00AA);
    check_eq("t1_busy", {31'd0, bus1.busy}, 32'd1);
    for (int k = 1; k <= LAT1; k++) begin
      if (k > 1) @(negedge clk);
      for (int j = 0; j < 7; j++)
        if (k == offs[j]) check_eq($sformatf("t1_cs_n_T%0d", k), {31'd0, bus1.cs_n}, {31'd0, exp_cs[j]});
    end
    check_eq("t1_done_pulse", {31'd0, bus1.done}, 32'd1);
    wait_done(1);

    // Random words.
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      start_txn(16'($urandom), 16'($urandom));
      wait_done(n_done + 1);
    end

    // start held high: one transaction, second accepted in the done cycle.
    @(negedge clk);
    dn = n_done;
    t0 = cyc;
    bus1.xdata_tx = 16'hC0DE; bus1.ydata_tx = 16'h1F2E; bus1.start = 1'b1;
    q_frame.push_back(16'hC0DE); q_frame.push_back(16'h1F2E);
    q_rx.push_back(EXP_RX); q_t0.push_back(t0);
    @(negedge clk);
    bus1.xdata_tx = 16'h5A01; bus1.ydata_tx = 16'hB00B;
    q_frame.push_back(16'h5A01); q_frame.push_back(16'hB00B);
    q_rx.push_back(EXP_RX); q_t0.push_back(t0 + LAT1);
    for (int k = 2; k <= LAT1 + 1; k++) begin
      @(negedge clk);
      if (k == 200) check_eq("hold_busy_mid", {31'd0, bus1.busy}, 32'd1);
    end
    check_eq("hold_cs_after_done", {31'd0, bus1.cs_n}, 32'd0);
    check_eq("hold_busy_after_done", {31'd0, bus1.busy}, 32'd1);
    check_eq("hold_one_done", 32'(n_done - dn), 32'd1);
    bus1.start = 1'b0;
    wait_done(dn + 2);

    // Reset mid-frame at T0+50.
    @(negedge clk);
    start_txn(16'hF00F, 16'h0FF0);
    dn = n_done;
    for (int k = 2; k <= 50; k++) @(negedge clk);
    reset = 1'b1;
    abort_flag = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_cs_n", {31'd0, bus1.cs_n}, 32'd1);
    check_eq("abort_sclk", {31'd0, bus1.sclk}, 32'd0);
    check_eq("abort_busy", {31'd0, bus1.busy}, 32'd0);
    check_eq("abort_rx",   bus1.rx_data, 32'd0);
    repeat (300) @(negedge clk);
    check_eq("abort_no_done", 32'(n_done - dn), 32'd0);
    q_frame.delete(); q_rx.delete(); q_t0.delete();
    abort_flag = 1'b0;
    start_txn(16'h8155, 16'h00AA);
    wait_done(dn + 1);

    // CLK_DIV=2, CS_GAP=1 instance; xdata_tx changes at T0+5.
    @(negedge clk);
    t0 = cyc;
    bus2.xdata_tx = 16'hC3A5; bus2.ydata_tx = 16'h5A3C; bus2.start = 1'b1;
    q2.push_back(16'hC3A5); q2.push_back(16'h5A3C);
    p_sclk2 = bus2.sclk; p_cs2 = bus2.cs_n; fr2 = 16'd0;
    for (int k = 1; k <= 138; k++) begin
      @(negedge clk);
      bus2.start = 1'b0;
      if (k == 5) bus2.xdata_tx = 16'h0000;
      if (!p_sclk2 && bus2.sclk) fr2 = {fr2[14:0], bus2.mosi};
      if (!p_cs2 && bus2.cs_n) begin
        if (q2.size() == 0) check_eq("d2_frame_unexpected", 32'd1, 32'd0);
        else check_eq("d2_frame_mosi", {16'd0, fr2}, {16'd0, q2.pop_front()});
      end
      if (k == 1 || k == 68 || k == 70 || k == 137)
        check_eq($sformatf("d2_cs_low_T%0d", k), {31'd0, bus2.cs_n}, 32'd0);
      if (k == 69) check_eq("d2_cs_gap_T69", {31'd0, bus2.cs_n}, 32'd1);
      if (k == 137) check_eq("d2_done_early", {31'd0, bus2.done}, 32'd0);
      p_sclk2 = bus2.sclk; p_cs2 = bus2.cs_n;
    end
    check_eq("d2_done_T138", {31'd0, bus2.done}, 32'd1);
    check_eq("d2_busy_T138", {31'd0, bus2.busy}, 32'd0);
    check_eq("d2_frames_left", 32'(q2.size()), 32'd0);
    check_eq("d2_t0", 32'(cyc - t0), 32'd138);

    check_eq("sb_frames_left", 32'(q_frame.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
